// File: rtl/wb_pkg.sv
// Shared Wishbone widths and the default memory map for the data-bus interconnect.
// Slave selects are one bit wider than needed for N_SLV so that the value N_SLV can mean "no slave".
package wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    localparam int N_SLV_DEF = 4;

    // Slave 0 sits in the least significant word: 0 = memory, 1 = UART,
    // 2 = aux peripheral window, 3 = debug/test-result register block.
    localparam logic [N_SLV_DEF*WB_AW-1:0] SLV_BASE_DEF =
        {32'h8000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [N_SLV_DEF*WB_AW-1:0] SLV_MASK_DEF =
        {32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000};

    function automatic int sel_width(input int n_slv);
        return $clog2(n_slv + 1);
    endfunction

    localparam int SEL_W_DEF = sel_width(N_SLV_DEF);
    localparam logic [SEL_W_DEF-1:0] MISS_DEF = SEL_W_DEF'(N_SLV_DEF);

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational priority address decoder: the lowest-numbered matching slave wins,
// and no match returns the miss code N_SLV.
module wb_addr_decode
    import wb_pkg::*;
#(
    parameter int                       N_SLV    = N_SLV_DEF,
    parameter logic [N_SLV*WB_AW-1:0]   SLV_BASE = SLV_BASE_DEF,
    parameter logic [N_SLV*WB_AW-1:0]   SLV_MASK = SLV_MASK_DEF,
    parameter int                       SEL_W    = sel_width(N_SLV)
) (
    input  logic [WB_AW-1:0] adr_i,
    output logic [SEL_W-1:0] tgt_o
);

    logic [N_SLV-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLV; gi++) begin : g_hit
            assign hit[gi] = ((adr_i & SLV_MASK[gi*WB_AW +: WB_AW]) == SLV_BASE[gi*WB_AW +: WB_AW]);
        end
    endgenerate

    // Walk from the top down so the lowest index overwrites any higher match.
    always_comb begin
        tgt_o = SEL_W'(N_SLV);
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if (hit[k]) begin
                tgt_o = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/wb_slave_mux.sv
// Single-master to N-slave Wishbone B4 pipelined interconnect with in-order response
// tracking, decode-miss errors and a response watchdog.
module wb_slave_mux
    import wb_pkg::*;
#(
    parameter int                       N_SLV     = N_SLV_DEF,
    parameter logic [N_SLV*WB_AW-1:0]   SLV_BASE  = SLV_BASE_DEF,
    parameter logic [N_SLV*WB_AW-1:0]   SLV_MASK  = SLV_MASK_DEF,
    parameter int                       MAX_OUTST = 4,
    parameter int                       TIMEOUT   = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      m_cyc_i,
    input  logic                      m_stb_i,
    input  logic                      m_we_i,
    input  logic [WB_AW-1:0]          m_adr_i,
    input  logic [WB_DW-1:0]          m_dat_i,
    input  logic [WB_SW-1:0]          m_sel_i,
    output logic                      m_stall_o,
    output logic                      m_ack_o,
    output logic                      m_err_o,
    output logic [WB_DW-1:0]          m_dat_o,
    output logic [N_SLV-1:0]          s_cyc_o,
    output logic [N_SLV-1:0]          s_stb_o,
    output logic                      s_we_o,
    output logic [WB_AW-1:0]          s_adr_o,
    output logic [WB_DW-1:0]          s_dat_o,
    output logic [WB_SW-1:0]          s_sel_o,
    input  logic [N_SLV-1:0]          s_stall_i,
    input  logic [N_SLV-1:0]          s_ack_i,
    input  logic [N_SLV-1:0]          s_err_i,
    input  logic [N_SLV*WB_DW-1:0]    s_dat_i
);

    localparam int SEL_W = sel_width(N_SLV);
    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [SEL_W-1:0] MISS = SEL_W'(N_SLV);

    logic [SEL_W-1:0] tgt;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_pend_q, err_pend_d;

    logic [N_SLV-1:0] cur_oh;
    logic [N_SLV-1:0] tgt_oh;
    logic             busy;
    logic             route;
    logic             slv_ack;
    logic             slv_err;
    logic             rsp_ack;
    logic             rsp_err;
    logic             rsp_any;
    logic             tmo_fire;
    logic             stall;
    logic             acc;
    logic             acc_slv;
    logic             acc_miss;
    logic [WB_DW-1:0] rsp_dat;

    wb_addr_decode #(
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .SEL_W    (SEL_W)
    ) u_addr_decode (
        .adr_i (m_adr_i),
        .tgt_o (tgt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_SLV; gi++) begin : g_slv
            assign cur_oh[gi]  = (cur_sel_q == SEL_W'(gi));
            assign tgt_oh[gi]  = (tgt == SEL_W'(gi));
            assign s_stb_o[gi] = wb_rst_ni & m_cyc_i & m_stb_i & tgt_oh[gi] & ~stall;
            assign s_cyc_o[gi] = wb_rst_ni & m_cyc_i & ((busy & cur_oh[gi]) | s_stb_o[gi]);
        end
    endgenerate

    assign s_we_o  = m_we_i;
    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;

    always_comb begin
        rsp_dat = '0;
        for (int k = 0; k < N_SLV; k++) begin
            rsp_dat = rsp_dat | (s_dat_i[k*WB_DW +: WB_DW] & {WB_DW{cur_oh[k]}});
        end
    end

    // Error beats ack when a slave drives both, so the master never sees them together.
    assign busy     = (outst_q != '0);
    assign route    = busy & (cur_sel_q != MISS);
    assign slv_ack  = |(s_ack_i & cur_oh);
    assign slv_err  = |(s_err_i & cur_oh);
    assign rsp_err  = route & slv_err;
    assign rsp_ack  = route & slv_ack & ~slv_err;
    assign rsp_any  = rsp_ack | rsp_err;
    assign tmo_fire = busy & ~rsp_any & (tmo_cnt_q == TMO_W'(TIMEOUT));

    assign stall = (outst_q == OUT_W'(MAX_OUTST))
                 | (busy & (tgt != cur_sel_q))
                 | (busy & (tgt == MISS))
                 | (|(s_stall_i & tgt_oh))
                 | err_pend_q;

    assign acc      = m_cyc_i & m_stb_i & ~stall;
    assign acc_slv  = acc & (tgt != MISS);
    assign acc_miss = acc & (tgt == MISS);

    assign m_stall_o = ~wb_rst_ni | stall;
    assign m_ack_o   = wb_rst_ni & rsp_ack;
    assign m_err_o   = wb_rst_ni & (rsp_err | err_pend_q | tmo_fire);
    assign m_dat_o   = (wb_rst_ni & rsp_ack) ? rsp_dat : '0;

    always_comb begin
        cur_sel_d  = acc ? tgt : cur_sel_q;
        // A miss never reaches a slave; the pending flag stands in for its response.
        err_pend_d = acc_miss;
        outst_d    = outst_q;
        tmo_cnt_d  = tmo_cnt_q;

        if (!m_cyc_i) begin
            outst_d = '0;
        end else if (tmo_fire) begin
            // Abort everything in flight, but keep a request accepted in the same beat.
            outst_d = OUT_W'(acc_slv);
        end else if (acc_slv && !rsp_any) begin
            outst_d = outst_q + OUT_W'(1);
        end else if (!acc_slv && rsp_any) begin
            outst_d = outst_q - OUT_W'(1);
        end

        if (!m_cyc_i || !busy || rsp_any || tmo_fire) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cur_sel_q  <= '0;
            outst_q    <= '0;
            tmo_cnt_q  <= '0;
            err_pend_q <= 1'b0;
        end else begin
            cur_sel_q  <= cur_sel_d;
            outst_q    <= outst_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_pend_q <= err_pend_d;
        end
    end

endmodule

// File: doc/wb_slave_mux.md
Name: wb_slave_mux

Overview:
Single-master to N-slave Wishbone B4 pipelined interconnect. It sits between the core data-bus master and the peripherals: memory, UART, and the debug/test-result slave. It decodes the request address and routes the request to one slave. It tracks outstanding transactions so that responses return to the master in order. It generates bus errors for unmapped addresses and for unresponsive slaves.

Parameters:
- N_SLV, 4, number of slave ports.
- SLV_BASE, {32'h8000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, flattened base address per slave (slave 0 in LSBs).
- SLV_MASK, {32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000}, flattened address mask per slave.
- MAX_OUTST, 4, maximum in-flight requests.
- TIMEOUT, 255, cycles without a response before the mux aborts.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  asynchronous reset, active-low.
- m_cyc_i, m_stb_i, m_we_i  in  1 each  master cycle, strobe, write enable.
- m_adr_i, m_dat_i  in  32 each  master address, write data.
- m_sel_i  in  4  master byte selects.
- m_stall_o, m_ack_o, m_err_o  out  1 each  stall, ack, and error to the master.
- m_dat_o  out  32  read data to the master.
- s_cyc_o, s_stb_o  out  N_SLV each  per-slave cycle and strobe.
- s_we_o, s_adr_o, s_dat_o, s_sel_o  out  1/32/32/4  broadcast to all slaves.
- s_stall_i, s_ack_i, s_err_i  in  N_SLV each  per-slave stall, ack, error.
- s_dat_i  in  32*N_SLV  per-slave read data, flattened.

Behaviour:
- Reset (wb_rst_ni low):
  - cur_sel=0, outst=0, tmo_cnt=0, err_pend=0.
  - m_ack_o=0, m_err_o=0, m_dat_o=0, m_stall_o=1.
  - All s_cyc_o and s_stb_o are 0. These values are forced while reset is asserted, regardless of other inputs.
- Decode (combinational):
  - hit[k] = ((m_adr_i & MASK_k) == BASE_k).
  - The lowest k with a hit wins and sets tgt = k.
  - No hit sets tgt = MISS.
- Stall: m_stall_o=1 when any of the following holds:
  - outst==MAX_OUTST;
  - outst!=0 and tgt!=cur_sel;
  - tgt==MISS and outst!=0;
  - tgt==k and s_stall_i[k];
  - err_pend.
- Accept: acc = m_cyc_i & m_stb_i & !m_stall_o.
  - On accept, cur_sel<=tgt.
  - Request path adds zero latency: s_stb_o[k] = m_cyc_i & m_stb_i & (tgt==k) & !m_stall_o.
- s_cyc_o[k] = m_cyc_i & ((outst!=0 & cur_sel==k) | s_stb_o[k]).
- Response routing: active only when outst!=0 and cur_sel!=MISS.
  - m_ack_o = s_ack_i[cur_sel] and m_err_o = s_err_i[cur_sel].
  - m_dat_o = s_dat_i[cur_sel] when ack is high, otherwise 0.
  - Responses from unselected slaves are ignored.
- Outstanding counter:
  - +1 on acc.
  - -1 on a routed ack or err.
  - Unchanged when both happen in the same cycle.
  - Never wraps; stall guarantees an upper bound of MAX_OUTST.
- Decode miss:
  - Accepted only when outst==0.
  - Sets err_pend; m_err_o=1 exactly one cycle later for one cycle, then err_pend clears.
  - No s_stb_o is asserted for a miss.
- Timeout:
  - tmo_cnt increments each cycle with outst!=0 and no routed response; it clears on any response or when outst==0.
  - On tmo_cnt==TIMEOUT: m_err_o=1 for one cycle, outst<=0, tmo_cnt<=0.
  - The master treats this as an abort of all in-flight requests.
- Master drops m_cyc_i with outst!=0: next cycle outst<=0 and all s_cyc_o are 0. Later slave acks are ignored.
- Wishbone rule: m_ack_o and m_err_o are never high together. If a slave asserts both, err wins and ack is masked.

Decomposition:
- Package wb_pkg holds:
  - WB_AW=32, WB_DW=32, WB_SW=4;
  - the MISS encoding, which is N_SLV, stored in a $clog2(N_SLV+1)-bit select;
  - the default memory-map constants.
- Sub-module wb_addr_decode: purely combinational priority decoder (m_adr_i -> tgt). It is reused by future multi-master crossbars.

Test Plan:
1. Single write to 0x8000_0000, data 0x1: only s_stb_o[3] pulses for 1 cycle. Slave acks 1 cycle later -> m_ack_o=1 for 1 cycle; outst returns 0.
2. Four back-to-back reads at 0x1000_0000..0x1000_000C with slave 1 ack latency 3: no stall for the first 4 requests. A 5th request stalls until the first ack. m_dat_o shows the 4 slave read values in order.
3. Read at 0x1000_0000 outstanding, then request to 0x2000_0004 -> m_stall_o=1 until the slave 1 ack, then s_stb_o[2] asserts in the following accepted cycle.
4. Access 0x4000_0000 (unmapped) with outst=0 -> accepted; no s_stb_o; m_err_o=1 exactly 1 cycle later.
5. Slave 0 never acks after a read of 0x0000_0010 -> m_err_o pulses on cycle 256 after accept; outst=0; the next request proceeds normally.
6. Assert wb_rst_ni low with 2 requests outstanding -> outputs return to reset values immediately. After release, a late s_ack_i[1] produces no m_ack_o.
